dmem_port_arbiter: RTL and testbench

//   Shares the single-port data memory between two requesters: the CPU load/store path and a debug/loader port.

---
 rtl/dmem_port_arbiter.sv | 104 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU and a debug/loader port.
// One access accepted per cycle; load data returns two cycles after the grant.
module dmem_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wd,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    ACC_CPU,
    ACC_DBG
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              last_win_dbg;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wd;
  logic              unused_cpu_addr;

  // Word index wraps modulo 2^ADDR_W; the upper ALU result bits carry no meaning here.
  assign unused_cpu_addr = ^cpu_addr[31:ADDR_W];

  // On a conflict the CPU wins unless it won the previous grant.
  always_comb begin
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    state_next = IDLE;
    if (!RST) begin
      if (cpu_req && (!dbg_req || last_win_dbg)) begin
        cpu_gnt    = 1'b1;
        state_next = ACC_CPU;
      end else if (dbg_req) begin
        dbg_gnt    = 1'b1;
        state_next = ACC_DBG;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      last_win_dbg <= 1'b1;
      cap_we       <= 1'b0;
      cap_addr     <= '0;
      cap_wd       <= '0;
    end else begin
      state <= state_next;
      if (cpu_gnt) begin
        last_win_dbg <= 1'b0;
        cap_we       <= cpu_we;
        cap_addr     <= cpu_addr[ADDR_W-1:0];
        cap_wd       <= cpu_wd;
      end else if (dbg_gnt) begin
        last_win_dbg <= 1'b1;
        cap_we       <= dbg_we;
        cap_addr     <= dbg_addr;
        cap_wd       <= dbg_wd;
      end
    end
  end

  // Gating with RST keeps an access caught by reset from corrupting memory.
  assign mem_we   = cap_we && (state != IDLE) && !RST;
  assign mem_addr = cap_addr;
  assign mem_wd   = cap_wd;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_rvalid <= (state == ACC_CPU) && !cap_we;
      dbg_rvalid <= (state == ACC_DBG) && !cap_we;
      if ((state == ACC_CPU) && !cap_we) cpu_rdata <= mem_rd;
      if ((state == ACC_DBG) && !cap_we) dbg_rdata <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter: a transaction-level model predicts grants,
// memory writes and load returns from the arbitration rules and a reference memory.
module tb_dmem_port_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int WORDS  = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0]       cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wd = '0;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req = 1'b0, dbg_we = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_wd = '0;
  logic              dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd, mem_rd;

  logic [DATA_W-1:0] ram [WORDS];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] model_mem [WORDS];
  bit                model_last_dbg;
  bit                pend_valid, pend_dbg, pend_we;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_wd;
  bit                exp_rv_cpu, exp_rv_dbg;
  logic [DATA_W-1:0] exp_rd_cpu, exp_rd_dbg;
  bit                g_cpu, g_dbg;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 CLK = ~CLK;

  assign mem_rd = ram[mem_addr];
  always @(posedge CLK) if (mem_we) ram[mem_addr] <= mem_wd;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Called just after a rising edge: a port issues a fresh request only once its last one was granted.
  task automatic applyStimulus(input int cpu_pct, input int dbg_pct, input int rst_pct);
    RST = ($urandom_range(0, 99) < rst_pct);
    if (!cpu_req || g_cpu) begin
      cpu_req  = ($urandom_range(0, 99) < cpu_pct);
      cpu_we   = $urandom_range(0, 1) == 1;
      cpu_addr = ($urandom() & 32'hFFFF_FFE0) | 32'($urandom_range(0, 7));
      cpu_wd   = $urandom();
    end
    if (!dbg_req || g_dbg) begin
      dbg_req  = ($urandom_range(0, 99) < dbg_pct);
      dbg_we   = $urandom_range(0, 1) == 1;
      dbg_addr = ADDR_W'($urandom_range(0, 7));
      dbg_wd   = $urandom();
    end
  endtask

  // Check one cycle at the falling edge, advance the model, then drive the next inputs.
  task automatic stepCycle(input int cpu_pct, input int dbg_pct, input int rst_pct);
    bit eg_cpu, eg_dbg, exp_we;
    @(negedge CLK);
    eg_cpu = !RST && cpu_req && (!dbg_req || model_last_dbg);
    eg_dbg = !RST && dbg_req && !eg_cpu;
    checkOutput("cpu_gnt", 32'(cpu_gnt), 32'(eg_cpu));
    checkOutput("dbg_gnt", 32'(dbg_gnt), 32'(eg_dbg));
    checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_rv_cpu));
    checkOutput("dbg_rvalid", 32'(dbg_rvalid), 32'(exp_rv_dbg));
    checkOutput("cpu_rdata", cpu_rdata, exp_rd_cpu);
    checkOutput("dbg_rdata", dbg_rdata, exp_rd_dbg);
    exp_we = pend_valid && pend_we && !RST;
    checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
    if (pend_valid && !RST) begin
      checkOutput("mem_addr", 32'(mem_addr), 32'(pend_addr));
      if (pend_we) checkOutput("mem_wd", mem_wd, pend_wd);
    end

    exp_rv_cpu = 1'b0;
    exp_rv_dbg = 1'b0;
    if (RST) begin
      exp_rd_cpu     = '0;
      exp_rd_dbg     = '0;
      model_last_dbg = 1'b1;
    end else if (pend_valid) begin
      if (pend_we) model_mem[pend_addr] = pend_wd;
      else if (pend_dbg) begin
        exp_rv_dbg = 1'b1;
        exp_rd_dbg = model_mem[pend_addr];
      end else begin
        exp_rv_cpu = 1'b1;
        exp_rd_cpu = model_mem[pend_addr];
      end
    end

    pend_valid = eg_cpu || eg_dbg;
    pend_dbg   = eg_dbg;
    pend_we    = eg_cpu ? cpu_we : dbg_we;
    pend_addr  = eg_cpu ? cpu_addr[ADDR_W-1:0] : dbg_addr;
    pend_wd    = eg_cpu ? cpu_wd : dbg_wd;
    if (eg_cpu) model_last_dbg = 1'b0;
    if (eg_dbg) model_last_dbg = 1'b1;
    g_cpu = eg_cpu;
    g_dbg = eg_dbg;

    @(posedge CLK);
    #1;
    applyStimulus(cpu_pct, dbg_pct, rst_pct);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram[i]       = $urandom();
      model_mem[i] = ram[i];
    end
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    model_last_dbg = 1'b1;
    pend_valid     = 1'b0;
    pend_dbg       = 1'b0;
    pend_we        = 1'b0;
    pend_addr      = '0;
    pend_wd        = '0;
    exp_rv_cpu     = 1'b0;
    exp_rv_dbg     = 1'b0;
    exp_rd_cpu     = '0;
    exp_rd_dbg     = '0;
    g_cpu          = 1'b0;
    g_dbg          = 1'b0;
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_mem_wd", mem_wd, 32'd0);
    applyStimulus(100, 100, 0);

    $display("[TB] both ports requesting continuously");
    repeat (6) stepCycle(100, 100, 0);
    $display("[TB] debug port alone, back-to-back");
    repeat (4) stepCycle(0, 100, 0);
    $display("[TB] random traffic");
    repeat (400) stepCycle(60, 60, 0);
    $display("[TB] random traffic with reset pulses");
    repeat (400) stepCycle(70, 70, 4);
    $display("[TB] draining");
    repeat (4) stepCycle(0, 0, 0);

    for (int i = 0; i < WORDS; i++) checkOutput("ram_word", ram[i], model_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
